// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost direction picker.
package ghost_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } picker_state_t;

  localparam int RND_W = 8;

  // Deterministic fallback: the lowest-numbered legal direction.
  function automatic logic [1:0] lowest_dir(input logic [3:0] mask);
    logic [1:0] d;
    d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) d = 2'(i);
    end
    return d;
  endfunction

  function automatic logic [RND_W-1:0] rand_next(input logic [RND_W-1:0] r);
    return {r[6:0], ~(r[7] ^ r[3])};
  endfunction

endpackage

// File: rtl/ghost_dir_picker_rand8_src.sv
// Free-running 8-bit XNOR shift register; starts at 00 and never reaches FF.
module rand8_src
  import ghost_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic [RND_W-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset) out <= '0;
    else       out <= rand_next(out);
  end

endmodule

// File: rtl/ghost_dir_picker.sv
// Picks a random legal ghost direction from a move mask, with a bounded number
// of draws and a lowest-bit fallback.
module ghost_dir_picker
  import ghost_pkg::*;
#(
  parameter int MAX_TRIES  = 8,
  parameter bit NO_REVERSE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [3:0]       allowed,
  input  logic [1:0]       cur_dir,
  output logic             busy,
  output logic             valid,
  output logic [1:0]       dir,
  output logic             stuck,
  output logic [RND_W-1:0] rnd
);

  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  picker_state_t state;
  logic [3:0]    tries;
  logic [3:0]    eff;
  logic [1:0]    pick;
  logic          pick_stuck;

  logic [1:0] rev;
  logic [3:0] no_rev;
  logic [3:0] eff_in;
  logic [1:0] cand;

  rand8_src u_rand (
    .clk   (clk),
    .reset (reset),
    .out   (rnd)
  );

  // The reverse move is dropped only if something else remains legal.
  always_comb begin
    rev    = cur_dir + 2'd2;
    no_rev = allowed & ~(4'b0001 << rev);
    eff_in = (NO_REVERSE && (no_rev != 4'b0000)) ? no_rev : allowed;
    cand   = rnd[1:0];
  end

  assign busy = (state != IDLE);

  // eff, pick and pick_stuck are always written before they are consumed,
  // so only the control state is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tries <= '0;
      valid <= 1'b0;
      dir   <= '0;
      stuck <= 1'b0;
    end else begin
      valid <= 1'b0;
      stuck <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            eff   <= eff_in;
            tries <= '0;
            if (eff_in == 4'b0000) begin
              pick       <= cur_dir;
              pick_stuck <= 1'b1;
              state      <= DONE;
            end else begin
              pick_stuck <= 1'b0;
              state      <= SEARCH;
            end
          end
        end
        SEARCH: begin
          if (eff[cand]) begin
            pick  <= cand;
            state <= DONE;
          end else if (tries == LAST_TRY) begin
            pick  <= lowest_dir(eff);
            state <= DONE;
          end else begin
            tries <= tries + 4'd1;
          end
        end
        DONE: begin
          valid <= 1'b1;
          dir   <= pick;
          stuck <= pick_stuck;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_dir_picker.sv
// Self-checking bench for ghost_dir_picker: default and MAX_TRIES=4 instances.
module tb_ghost_dir_picker;
  import ghost_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req8 = 1'b0;
  logic       req4 = 1'b0;
  logic [3:0] allowed = 4'b0000;
  logic [1:0] cur_dir = 2'd0;

  logic       busy8, valid8, stuck8;
  logic [1:0] dir8;
  logic [7:0] rnd8;
  logic       busy4, valid4, stuck4;
  logic [1:0] dir4;
  logic [7:0] rnd4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ghost_dir_picker dut8 (
    .clk(clk), .reset(reset), .req(req8), .allowed(allowed), .cur_dir(cur_dir),
    .busy(busy8), .valid(valid8), .dir(dir8), .stuck(stuck8), .rnd(rnd8)
  );

  ghost_dir_picker #(.MAX_TRIES(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .allowed(allowed), .cur_dir(cur_dir),
    .busy(busy4), .valid(valid4), .dir(dir4), .stuck(stuck4), .rnd(rnd4)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], ~(r[7] ^ r[3])};
  endfunction

  logic [7:0] m_rnd;
  always @(posedge clk) m_rnd <= reset ? 8'h00 : lfsr_step(m_rnd);

  typedef struct {
    logic [1:0] dir;
    logic       stuck;
    int         lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] al;
    logic [1:0] cd;
    bit         use4;
    logic [1:0] dir;
    logic       stuck;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
    end
  endtask

  // r0 is the random state just before the sampling edge.
  function automatic exp_t predict(input logic [7:0] r0, input logic [3:0] al,
                                   input logic [1:0] cd, input int maxt);
    exp_t e;
    logic [3:0] m, eff;
    logic [7:0] r;
    int rv;
    bit found;
    rv = (int'(cd) + 2) % 4;
    m = al & ~(4'b0001 << rv);
    eff = (m != 4'b0000) ? m : al;
    e.stuck = 1'b0;
    if (eff == 4'b0000) begin
      e.dir = cd; e.stuck = 1'b1; e.lat = 1;
      return e;
    end
    r = r0;
    found = 1'b0;
    e.dir = 2'd0;
    e.lat = maxt + 1;
    for (int t = 0; t < maxt; t++) begin
      r = lfsr_step(r);
      if (!found && eff[r[1:0]]) begin
        found = 1'b1; e.dir = r[1:0]; e.lat = t + 2;
      end
    end
    if (!found) begin
      for (int i = 3; i >= 0; i--) if (eff[i]) e.dir = 2'(i);
    end
    return e;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge. Inputs are scrambled after the sampling edge.
  task automatic issue(input bit use4, input logic [3:0] al, input logic [1:0] cd,
                       input bit hold, output logic [1:0] d, output logic s,
                       output int lat);
    exp_t e;
    int k;
    bit got;
    logic v;
    allowed = al;
    cur_dir = cd;
    if (use4) req4 = 1'b1; else req8 = 1'b1;
    sb.push_back(predict(m_rnd, al, cd, use4 ? 4 : 8));
    k = 0; got = 1'b0; d = 2'd0; s = 1'b0; lat = -1;
    while (k < 40 && !got) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        if (!hold) begin req4 = 1'b0; req8 = 1'b0; end
        allowed = ~al;
        cur_dir = cd + 2'd1;
      end
      v = use4 ? valid4 : valid8;
      if (v) begin
        got = 1'b1;
        d = use4 ? dir4 : dir8;
        s = use4 ? stuck4 : stuck8;
        lat = k - 1;
      end
    end
    req4 = 1'b0; req8 = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      check("valid_timeout", 0, 1);
    end else begin
      check("dir", d, e.dir);
      check("stuck", s, e.stuck);
      check("latency", lat, e.lat);
      check("rnd_track", use4 ? rnd4 : rnd8, m_rnd);
      @(posedge clk); #1;
      check("valid_one_cycle", use4 ? valid4 : valid8, 0);
      check("dir_hold", use4 ? dir4 : dir8, d);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] d;
    logic s;
    int lat, cnt;

    tbl[0] = '{4'b0000, 2'd3, 1'b0, 2'd3, 1'b1};
    tbl[1] = '{4'b0000, 2'd1, 1'b1, 2'd1, 1'b1};
    tbl[2] = '{4'b0010, 2'd0, 1'b0, 2'd1, 1'b0};
    tbl[3] = '{4'b1100, 2'd0, 1'b0, 2'd3, 1'b0};
    tbl[4] = '{4'b0100, 2'd0, 1'b1, 2'd2, 1'b0};
    tbl[5] = '{4'b1000, 2'd1, 1'b0, 2'd3, 1'b0};
    tbl[6] = '{4'b0001, 2'd3, 1'b1, 2'd0, 1'b0};
    tbl[7] = '{4'b0011, 2'd3, 1'b0, 2'd0, 1'b0};

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_valid", valid8, 0);
    check("reset_dir", dir8, 0);
    check("reset_stuck", stuck8, 0);
    check("reset_rnd", rnd8, 0);
    @(negedge clk);
    reset = 1'b0;

    // First request after reset, all moves legal: candidate 1 accepted.
    issue(1'b0, 4'b1111, 2'd0, 1'b0, d, s, lat);
    check("first_dir", d, 1);
    check("first_stuck", s, 0);
    check("first_lat", lat, 2);

    issue(1'b0, 4'b0000, 2'd3, 1'b0, d, s, lat);
    check("empty_dir", d, 3);
    check("empty_stuck", s, 1);
    check("empty_lat", lat, 1);

    // Reverse-only mask, six draws on the default instance.
    do_reset();
    issue(1'b0, 4'b0001, 2'd2, 1'b0, d, s, lat);
    check("revonly_dir", d, 0);
    check("revonly_lat", lat, 7);

    // Same start with MAX_TRIES=4: fallback after four rejects.
    do_reset();
    issue(1'b1, 4'b0001, 2'd2, 1'b0, d, s, lat);
    check("fallback_dir", d, 0);
    check("fallback_stuck", s, 0);
    check("fallback_lat", lat, 5);

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].use4, tbl[i].al, tbl[i].cd, 1'b0, d, s, lat);
      check($sformatf("tbl%0d_dir", i), d, tbl[i].dir);
      check($sformatf("tbl%0d_stuck", i), s, tbl[i].stuck);
    end

    for (int i = 0; i < 6; i++) begin
      issue(i[0], 4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)), 1'b0, d, s, lat);
    end

    // req held high for the whole search: one pulse, nothing after.
    issue(1'b0, 4'b0001, 2'd2, 1'b1, d, s, lat);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (valid8) cnt++;
    end
    check("held_req_extra_valid", cnt, 0);
    @(negedge clk);

    // Reset in the middle of a long search.
    do_reset();
    allowed = 4'b0001;
    cur_dir = 2'd2;
    req8 = 1'b1;
    @(posedge clk); #1;
    req8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_busy", busy8, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_valid", valid8, 0);
    check("abort_rnd", rnd8, 0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (valid8) cnt++;
    end
    check("abort_no_valid", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghost_dir_picker.md
GHOST_DIR_PICKER -- requirements
Module: ghost_dir_picker

Interface
REQ-001 Parameter MAX_TRIES, default 8, SHALL set the number of random draws before the deterministic fallback (range 1..15).
REQ-002 Parameter NO_REVERSE, default 1, SHALL (when 1) exclude the reverse of cur_dir unless it is the only allowed direction.
REQ-003 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  1  request a new direction; sampled only in IDLE.
REQ-006 allowed  in  4  legal-move mask: bit0 UP, bit1 RIGHT, bit2 DOWN, bit3 LEFT; sampled with req.
REQ-007 cur_dir  in  2  current ghost direction; sampled with req.
REQ-008 busy  out  1  high while in SEARCH or DONE.
REQ-009 valid  out  1  one-cycle pulse; dir and stuck are valid while it is high.
REQ-010 dir  out  2  chosen direction; holds its value until the next valid.
REQ-011 stuck  out  1  high with valid when the effective mask was empty.
REQ-012 rnd  out  8  current random-source state, for debug and reuse.

Function
REQ-013 The random source SHALL be an 8-bit register that free-runs every cycle: next = {r[6:0], ~(r[7]^r[3])}.
- After reset the sequence SHALL be 00,01,03,07,0F,1E,3C,78,F0,E0...
- State FF is the lock-up state and is unreachable from 00.
REQ-014 The FSM SHALL have three states: IDLE, SEARCH and DONE.
REQ-015 IDLE with req=1 SHALL latch the effective mask and go to SEARCH, with the try counter cleared to 0.
- rev = (cur_dir+2) mod 4.
- eff = allowed & ~(1<<rev) when NO_REVERSE=1 and that result is nonzero; otherwise eff = allowed.
REQ-016 IDLE with req=1 and eff=0 SHALL go straight to DONE with stuck=1 and dir=cur_dir.
REQ-017 In SEARCH, each cycle the candidate SHALL be rnd[1:0].
- If eff[cand]=1: dir<=cand, go to DONE.
- Otherwise the try counter SHALL increment.
REQ-018 A rejection on try MAX_TRIES (counter = MAX_TRIES-1) SHALL set dir to the lowest set bit of eff and go to DONE.
REQ-019 DONE SHALL assert valid for exactly one cycle and then return to IDLE.
REQ-020 Latency from the req-sampling edge to valid SHALL be minimum 2 cycles and maximum MAX_TRIES+1 cycles; on the stuck path it SHALL be 1 cycle.
REQ-021 req while busy=1 SHALL be ignored, with no queueing.
REQ-022 allowed and cur_dir changes after the sampling edge SHALL NOT affect the in-flight search.
REQ-023 stuck SHALL be 0 on every non-empty-mask completion.

Reset
REQ-024 reset SHALL set the state to IDLE, the random register to 00, the try counter to 0, and busy, valid, dir, stuck and rnd to 0; reset has priority over every other event.
REQ-025 reset asserted during SEARCH or DONE SHALL abort with no valid pulse, and the aborted request SHALL be lost.

Structure
REQ-026 Package ghost_pkg SHALL hold:
- dir_t enum (UP=0, RIGHT=1, DOWN=2, LEFT=3);
- picker_state_t enum (IDLE, SEARCH, DONE);
- constant RND_W=8.
REQ-027 The random register SHALL be a sub-module rand8_src (clk, reset, out[7:0]), always enabled; the FSM stays in ghost_dir_picker.

Verification
REQ-028 Default parameters. First cycle after reset: req=1, allowed=1111, cur_dir=0. Then eff=1011, the SEARCH cycle sees rnd=01, and dir=1 (RIGHT), valid=1, stuck=0 two cycles after the req edge.
REQ-029 Default parameters. allowed=0000, cur_dir=3, req=1. Then valid=1 one cycle later, stuck=1, dir=3.
REQ-030 Default parameters. Request on the first cycle after reset: allowed=0001, cur_dir=2 (reverse-only case, eff=0001). Candidates are 1,3,3,3,2,0, so dir=0 on the 6th SEARCH cycle, with valid 7 cycles after the req edge.
REQ-031 Same as REQ-030 with MAX_TRIES=4. Four rejects, then fallback dir=0, with valid 5 cycles after the req edge.
REQ-032 req held high through a whole search: exactly one valid pulse, and a new search starts only from IDLE.
REQ-033 reset pulsed during SEARCH: the next cycle shows busy=0, valid=0, rnd=00, and no valid pulse appears afterwards.
